floating_point_accumulator: RTL
===============================

Name: floating_point_accumulator

Overview:
- Sequential stream reducer that sits around floating_point_adder and both feeds it and consumes its result.
- It sums a packet of floats, delimited by `in_last`, into one result register.
- It presents the packet sum with an element count and sticky exception flags on a valid/ready output.
- It is used by vector-reduction and dot-product datapaths downstream of multipliers.

Parameters:
- EXPONENT_WIDTH, 8: exponent field width, passed to the adder.
- MANTISSA_WIDTH, 23: stored mantissa width, passed to the adder.
- ROUND_TO_NEAREST, 1: adder rounding mode, passed through.
- ROUNDING_BITS, 3: adder guard bits, passed through.
- COUNT_WIDTH, 16: width of the element counter.

Ports:
- clk  input  1  clock; all state on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- in_data  input  EXPONENT_WIDTH+MANTISSA_WIDTH+1  float operand, sign/exponent/mantissa packed.
- in_subtract  input  1  beat is subtracted (its sign is inverted) instead of added.
- in_last  input  1  beat closes the packet.
- out_valid  output  1  packet result available.
- out_ready  input  1  consumer takes the result.
- out_data  output  EXPONENT_WIDTH+MANTISSA_WIDTH+1  packet sum.
- out_count  output  COUNT_WIDTH  number of beats in the packet, saturating.
- out_underflow  output  1  sticky OR of adder underflow_flag over the packet.
- out_overflow  output  1  sticky OR of adder overflow_flag over the packet.
- out_invalid  output  1  sticky OR of adder invalid_operation_flag over the packet.

Behaviour:
- The block instantiates one floating_point_adder combinationally: a = accumulator register, b = in_data, subtract = in_subtract.
- States are FIRST, ACCUM and DONE. Reset value is FIRST.
- Reset, asynchronous, forces: accumulator 0, count 0, flags 0, out_valid 0, and state FIRST. out_data, out_count and the out_* flags reflect the cleared registers.
- Reset mid-packet discards the partial sum; the next accepted beat starts a new packet.
- in_ready = (state != DONE) || out_ready. A beat is accepted when in_valid && in_ready.
- FIRST, beat accepted:
  - accumulator <= in_data, with the sign bit inverted if in_subtract; the adder is bypassed.
  - count <= 1; flags cleared.
  - Go to DONE if in_last, else ACCUM.
- ACCUM, beat accepted:
  - accumulator <= adder out.
  - count <= count+1, holding at all-ones once reached.
  - flags |= adder flags.
  - Go to DONE if in_last.
- No beat accepted in FIRST or ACCUM: all registers hold.
- DONE:
  - out_valid = 1; out_data, out_count and flags are stable until the handshake.
  - out_valid && out_ready with no input: out_valid drops next cycle; go to FIRST.
  - Simultaneous out handshake and an accepted beat: that beat is handled exactly as in FIRST in the same cycle. Zero-bubble back-to-back packets are allowed.
- Latency: out_valid rises on the cycle after the in_last beat is accepted. Throughput is 1 beat/cycle.
- out_valid is registered. in_ready is combinational from state and out_ready only, never from in_valid.
- in_data is not inspected for specials; NaN/Inf handling is whatever the adder produces.

Optional Feature:
- Macro: FLOAT_ACCUMULATOR_CLEAR_EN.
- When defined, adds input port `clear` (1 bit, synchronous, active-high). A clear cycle forces state FIRST, count 0, flags 0 and out_valid 0, and discards any beat offered that cycle.
- Clear has priority over every handshake; asynchronous rst still dominates clear.
- When undefined, the port does not exist and behaviour is as above.

Test Plan:
- Sum: beats 0x3F800000, 0x40000000, 0x40400000 (last), out_ready=1 -> out_data 0x40C00000 (6.0), out_count 3, flags 0, out_valid one cycle after the last beat.
- Single-beat packet: 0x40000000 with in_subtract=1 and in_last -> out_data 0xC0000000, out_count 1.
- Subtract: 0x40400000, then 0x3F800000 with in_subtract=1 (last) -> out_data 0x40000000, out_count 2.
- Backpressure: out_ready=0 for 5 cycles after a result -> out_data/out_count stable, in_ready=0. Then out_ready=1 with in_valid=1 carrying the first beat of the next packet -> beat accepted the same cycle, no bubble.
- Reset mid-packet: assert rst asynchronously after 2 beats, then send 0x3F800000 (last) -> out_data 0x3F800000, out_count 1, flags 0.
- With FLOAT_ACCUMULATOR_CLEAR_EN: clear pulsed between beat 2 and beat 3 of a packet -> only beat 3 onward is summed, out_count restarts at 1.

Source files
------------

// File: rtl/floating_point_accumulator.sv
// Packet-sum reducer built around a combinational floating-point adder.
// Optional synchronous clear port is enabled by defining FLOAT_ACCUMULATOR_CLEAR_EN.

// Combinational float adder: flushes subnormals, rounds per ROUND_TO_NEAREST.
module floating_point_adder #(
    parameter int unsigned EXPONENT_WIDTH   = 8,
    parameter int unsigned MANTISSA_WIDTH   = 23,
    parameter int unsigned ROUND_TO_NEAREST = 1,
    parameter int unsigned ROUNDING_BITS    = 3
) (
    input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] a,
    input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] b,
    input  logic                                   subtract,
    output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] out,
    output logic                                   underflow_flag,
    output logic                                   overflow_flag,
    output logic                                   invalid_operation_flag
);
    localparam int unsigned EW = EXPONENT_WIDTH;
    localparam int unsigned MW = MANTISSA_WIDTH;
    localparam int unsigned RB = ROUNDING_BITS;
    localparam int unsigned SW = MW + 1 + RB;
    localparam int          EXP_INF = (1 << EW) - 1;
    localparam logic [EW-1:0] EXP_MAX  = '1;
    localparam logic [MW-1:0] QNAN_MAN = {1'b1, {(MW-1){1'b0}}};
    localparam logic [RB-1:0] REST_MASK = RB'((64'd1 << (RB - 1)) - 64'd1);

    logic          sa, sb;
    logic [EW-1:0] ea, eb;
    logic [MW-1:0] ma, mb;
    logic          a_nan, b_nan, a_inf, b_inf;

    assign sa    = a[EW+MW];
    assign ea    = a[EW+MW-1:MW];
    assign ma    = a[MW-1:0];
    assign sb    = b[EW+MW] ^ subtract;
    assign eb    = b[EW+MW-1:MW];
    assign mb    = b[MW-1:0];
    assign a_nan = (ea == EXP_MAX) && (ma != '0);
    assign b_nan = (eb == EXP_MAX) && (mb != '0);
    assign a_inf = (ea == EXP_MAX) && (ma == '0);
    assign b_inf = (eb == EXP_MAX) && (mb == '0);

    logic          swap, s_big;
    logic [EW-1:0] e_big, e_small, diff;
    logic [MW-1:0] m_big, m_small;
    logic [SW-1:0] sig_big, sig_small, shifted, lost, aligned, norm;
    logic [SW:0]   sum;
    logic [MW+1:0] mant_r;
    logic [MW-1:0] frac;
    logic          guard, rest, round_up;
    int            msb, lz, exp_n;

    // Align, add, normalise, round and classify the result.
    always_comb begin
        out                    = '0;
        underflow_flag         = 1'b0;
        overflow_flag          = 1'b0;
        invalid_operation_flag = 1'b0;
        lz                     = 0;
        msb                    = -1;

        swap    = {eb, mb} > {ea, ma};
        s_big   = swap ? sb : sa;
        e_big   = swap ? eb : ea;
        e_small = swap ? ea : eb;
        m_big   = swap ? mb : ma;
        m_small = swap ? ma : mb;

        sig_big   = {(e_big != '0),   (e_big != '0)   ? m_big   : MW'(0), {RB{1'b0}}};
        sig_small = {(e_small != '0), (e_small != '0) ? m_small : MW'(0), {RB{1'b0}}};
        diff      = e_big - e_small;
        shifted   = sig_small >> diff;
        lost      = sig_small & ~({SW{1'b1}} << diff);
        aligned   = shifted | SW'(|lost);

        if (sa == sb) sum = {1'b0, sig_big} + {1'b0, aligned};
        else          sum = {1'b0, sig_big} - {1'b0, aligned};

        for (int i = 0; i < int'(SW); i++) begin
            if (sum[i]) msb = i;
        end

        if (sum[SW]) begin
            norm    = sum[SW:1];
            norm[0] = sum[1] | sum[0];
            exp_n   = int'(e_big) + 1;
        end else begin
            lz    = int'(SW) - 1 - msb;
            norm  = sum[SW-1:0] << lz;
            exp_n = int'(e_big) - lz;
        end

        guard    = norm[RB-1];
        rest     = |(norm[RB-1:0] & REST_MASK);
        round_up = (ROUND_TO_NEAREST != 0) && guard && (rest || norm[RB]);
        mant_r   = {1'b0, norm[SW-1:RB]} + (MW+2)'(round_up);
        if (mant_r[MW+1]) begin
            exp_n = exp_n + 1;
            frac  = mant_r[MW:1];
        end else begin
            frac  = mant_r[MW-1:0];
        end

        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
            out                    = {1'b0, EXP_MAX, QNAN_MAN};
            invalid_operation_flag = 1'b1;
        end else if (a_inf) begin
            out = {sa, EXP_MAX, MW'(0)};
        end else if (b_inf) begin
            out = {sb, EXP_MAX, MW'(0)};
        end else if (sum == '0) begin
            out = {sa & sb, (EW+MW)'(0)};
        end else if (exp_n <= 0) begin
            out            = {s_big, (EW+MW)'(0)};
            underflow_flag = 1'b1;
        end else if (exp_n >= EXP_INF) begin
            out           = {s_big, EXP_MAX, MW'(0)};
            overflow_flag = 1'b1;
        end else begin
            out = {s_big, EW'(exp_n), frac};
        end
    end
endmodule

module floating_point_accumulator #(
    parameter int unsigned EXPONENT_WIDTH   = 8,
    parameter int unsigned MANTISSA_WIDTH   = 23,
    parameter int unsigned ROUND_TO_NEAREST = 1,
    parameter int unsigned ROUNDING_BITS    = 3,
    parameter int unsigned COUNT_WIDTH      = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] in_data,
    input  logic                                   in_subtract,
    input  logic                                   in_last,
`ifdef FLOAT_ACCUMULATOR_CLEAR_EN
    input  logic                                   clear,
`endif
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] out_data,
    output logic [COUNT_WIDTH-1:0]                 out_count,
    output logic                                   out_underflow,
    output logic                                   out_overflow,
    output logic                                   out_invalid
);
    localparam int unsigned DW = EXPONENT_WIDTH + MANTISSA_WIDTH + 1;

    typedef enum logic [1:0] {FIRST, ACCUM, DONE} state_t;

    state_t                 state_q, state_n;
    logic [DW-1:0]          acc_q, acc_n, add_out;
    logic [COUNT_WIDTH-1:0] count_q, count_n;
    logic                   unf_q, unf_n, ovf_q, ovf_n, inv_q, inv_n;
    logic                   valid_q, valid_n;
    logic                   add_unf, add_ovf, add_inv;
    logic                   accept, load_first, add_beat;

    floating_point_adder #(
        .EXPONENT_WIDTH  (EXPONENT_WIDTH),
        .MANTISSA_WIDTH  (MANTISSA_WIDTH),
        .ROUND_TO_NEAREST(ROUND_TO_NEAREST),
        .ROUNDING_BITS   (ROUNDING_BITS)
    ) u_adder (
        .a                     (acc_q),
        .b                     (in_data),
        .subtract              (in_subtract),
        .out                   (add_out),
        .underflow_flag        (add_unf),
        .overflow_flag         (add_ovf),
        .invalid_operation_flag(add_inv)
    );

    assign in_ready      = (state_q != DONE) || out_ready;
    assign accept        = in_valid && in_ready;
    assign out_valid     = valid_q;
    assign out_data      = acc_q;
    assign out_count     = count_q;
    assign out_underflow = unf_q;
    assign out_overflow  = ovf_q;
    assign out_invalid   = inv_q;

    // Next-state and register updates for packet start, accumulation and result hand-off.
    always_comb begin
        state_n    = state_q;
        acc_n      = acc_q;
        count_n    = count_q;
        unf_n      = unf_q;
        ovf_n      = ovf_q;
        inv_n      = inv_q;
        valid_n    = valid_q;
        load_first = 1'b0;
        add_beat   = 1'b0;

        case (state_q)
            FIRST:   load_first = accept;
            ACCUM:   add_beat   = accept;
            DONE: begin
                if (out_ready) begin
                    state_n    = FIRST;
                    valid_n    = 1'b0;
                    load_first = accept;
                end
            end
            default: state_n = FIRST;
        endcase

        if (load_first) begin
            acc_n   = {in_data[DW-1] ^ in_subtract, in_data[DW-2:0]};
            count_n = COUNT_WIDTH'(1);
            unf_n   = 1'b0;
            ovf_n   = 1'b0;
            inv_n   = 1'b0;
        end
        if (add_beat) begin
            acc_n   = add_out;
            count_n = (&count_q) ? count_q : count_q + COUNT_WIDTH'(1);
            unf_n   = unf_q | add_unf;
            ovf_n   = ovf_q | add_ovf;
            inv_n   = inv_q | add_inv;
        end
        if (load_first || add_beat) begin
            state_n = in_last ? DONE : ACCUM;
            valid_n = in_last;
        end

`ifdef FLOAT_ACCUMULATOR_CLEAR_EN
        if (clear) begin
            state_n = FIRST;
            acc_n   = acc_q;
            count_n = '0;
            unf_n   = 1'b0;
            ovf_n   = 1'b0;
            inv_n   = 1'b0;
            valid_n = 1'b0;
        end
`endif
    end

    // State and result registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FIRST;
            acc_q   <= '0;
            count_q <= '0;
            unf_q   <= 1'b0;
            ovf_q   <= 1'b0;
            inv_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_n;
            acc_q   <= acc_n;
            count_q <= count_n;
            unf_q   <= unf_n;
            ovf_q   <= ovf_n;
            inv_q   <= inv_n;
            valid_q <= valid_n;
        end
    end
endmodule
